// File: rtl/note_pkg.sv
// Shared definitions for the note display path: ASCII codes, qualifier states and
// the 4-bit note codes also used by the note-to-ASCII stage.
package note_pkg;

  localparam logic [7:0]  ASCII_SPACE  = 8'h20;
  localparam logic [7:0]  ASCII_POUND  = 8'h23;
  localparam logic [15:0] NOTE_SILENCE = {ASCII_SPACE, ASCII_SPACE};

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    HELD
  } state_t;

  localparam logic [3:0] NOTE_C    = 4'd0;
  localparam logic [3:0] NOTE_CS   = 4'd1;
  localparam logic [3:0] NOTE_D    = 4'd2;
  localparam logic [3:0] NOTE_DS   = 4'd3;
  localparam logic [3:0] NOTE_E    = 4'd4;
  localparam logic [3:0] NOTE_F    = 4'd5;
  localparam logic [3:0] NOTE_FS   = 4'd6;
  localparam logic [3:0] NOTE_G    = 4'd7;
  localparam logic [3:0] NOTE_GS   = 4'd8;
  localparam logic [3:0] NOTE_A    = 4'd9;
  localparam logic [3:0] NOTE_AS   = 4'd10;
  localparam logic [3:0] NOTE_B    = 4'd11;
  localparam logic [3:0] NOTE_REST = 4'd15;

endpackage

// File: rtl/note_stability_qualifier.sv
// Debounces the incoming note: a value must be sampled HOLD_CYCLES+1 consecutive edges
// before o_commit_valid strobes (combinationally, so the parent registers it on that edge).
module note_stability_qualifier
  import note_pkg::*;
#(
  parameter int HOLD_CYCLES = 270000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_ascii_note,
  output logic        o_commit_valid,
  output logic [15:0] o_commit_value
);

  localparam int             CW      = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [15:0]   r_cand;
  logic [15:0]   w_cand_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_changed;

  assign w_changed = (i_ascii_note != r_cand);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cand  <= NOTE_SILENCE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any change of input restarts qualification, whatever the current state.
  always_comb begin
    w_next_state = r_state;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    if (w_changed) begin
      w_next_state = QUAL;
      w_cand_nxt   = i_ascii_note;
      w_cnt_nxt    = '0;
    end else if (r_state == QUAL) begin
      if (r_cnt == CNT_MAX) begin
        w_next_state = HELD;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_commit_valid = (r_state == QUAL) && !w_changed && (r_cnt == CNT_MAX);
    o_commit_value = r_cand;
  end

endmodule

// File: rtl/note_history_ticker.sv
// Records each newly committed note into a NUM_SLOTS-deep ASCII history for the display,
// pulsing o_new_note on every push; silence separates repeats but is never pushed.
module note_history_ticker
  import note_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int HOLD_CYCLES = 270000
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [15:0]             i_ascii_note,
  input  logic                    i_clear,
  output logic [16*NUM_SLOTS-1:0] o_history,
  output logic                    o_new_note,
  output logic [15:0]             o_current_note
);

  logic                    w_commit_valid;
  logic [15:0]             w_commit_value;
  logic [16*NUM_SLOTS-1:0] r_history;
  logic [16*NUM_SLOTS-1:0] w_shifted;
  logic [15:0]             r_last;
  logic                    r_new_note;

  note_stability_qualifier #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_qual (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_ascii_note   (i_ascii_note),
    .o_commit_valid (w_commit_valid),
    .o_commit_value (w_commit_value)
  );

  always_comb begin
    w_shifted       = r_history << 16;
    w_shifted[15:0] = w_commit_value;
  end

  // Clear outranks a same-edge commit; it does not disturb qualification in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_history  <= {NUM_SLOTS{NOTE_SILENCE}};
      r_last     <= NOTE_SILENCE;
      r_new_note <= 1'b0;
    end else begin
      r_new_note <= 1'b0;
      if (i_clear) begin
        r_history <= {NUM_SLOTS{NOTE_SILENCE}};
        r_last    <= NOTE_SILENCE;
      end else if (w_commit_valid && (w_commit_value != r_last)) begin
        r_last <= w_commit_value;
        if (w_commit_value != NOTE_SILENCE) begin
          r_history  <= w_shifted;
          r_new_note <= 1'b1;
        end
      end
    end
  end

  assign o_history      = r_history;
  assign o_new_note     = r_new_note;
  assign o_current_note = r_last;

endmodule

// File: tb/tb_note_history_ticker.sv
// Bench for note_history_ticker: directed scenarios plus random note runs scored
// against a run-length model of the stability and history rules.
module tb_note_history_ticker;

  localparam int HOLD = 4;
  localparam int NS   = 8;
  localparam logic [15:0]     SP     = 16'h2020;
  localparam logic [16*NS-1:0] ALL_SP = {NS{16'h2020}};

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [15:0]     ascii_note = 16'h2020;
  logic            clear = 1'b0;
  logic [16*NS-1:0] history;
  logic            new_note;
  logic [15:0]     current_note;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [15:0] m_slot [NS];
  logic [15:0] m_last;
  logic [15:0] m_val;
  int          m_len;
  logic        m_pulse;

  note_history_ticker #(
    .NUM_SLOTS   (NS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_ascii_note   (ascii_note),
    .i_clear        (clear),
    .o_history      (history),
    .o_new_note     (new_note),
    .o_current_note (current_note)
  );

  always #5 clk = ~clk;

  function automatic logic [16*NS-1:0] model_hist();
    logic [16*NS-1:0] v;
    for (int k = 0; k < NS; k++) v[16*k +: 16] = m_slot[k];
    return v;
  endfunction

  // Drive one edge, advance the model for that edge, then settle past it.
  task automatic tick(input logic [15:0] n, input logic clr, input logic rst);
    @(negedge clk);
    ascii_note = n;
    clear      = clr;
    reset      = rst;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < NS; k++) m_slot[k] = SP;
      m_last  = SP;
      m_val   = SP;
      m_len   = HOLD + 2;
      m_pulse = 1'b0;
    end else begin
      if (n != m_val) begin
        m_val = n;
        m_len = 1;
      end else if (m_len < HOLD + 2) begin
        m_len++;
      end
      m_pulse = 1'b0;
      if (clr) begin
        for (int k = 0; k < NS; k++) m_slot[k] = SP;
        m_last = SP;
      end else if (m_len == HOLD + 1 && m_val != m_last) begin
        m_last = m_val;
        if (m_val != SP) begin
          for (int k = NS - 1; k > 0; k--) m_slot[k] = m_slot[k-1];
          m_slot[0] = m_val;
          m_pulse   = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(SP, 1'b0, 1'b1);
    tick(SP, 1'b0, 1'b1);
    n_tests++;
    if (history !== ALL_SP || new_note !== 1'b0 || current_note !== SP) begin
      n_fail++;
      $display("FAIL reset_state: hist=%h nn=%b cur=%h expected hist=%h nn=0 cur=%h", history, new_note, current_note, ALL_SP, SP);
    end
    for (int i = 0; i < 20; i++) begin
      tick(SP, 1'b0, 1'b0);
      n_tests++;
      if (history !== ALL_SP || new_note !== 1'b0 || current_note !== SP) begin
        n_fail++;
        $display("FAIL reset_silence[%0d]: hist=%h nn=%b cur=%h expected all spaces, nn=0", i, history, new_note, current_note);
      end
    end
  endtask

  task automatic test_single_note();
    logic exp_nn;
    for (int i = 0; i < 5; i++) begin
      tick(16'h4320, 1'b0, 1'b0);
      exp_nn = (i == 4);
      n_tests++;
      if (new_note !== exp_nn) begin
        n_fail++;
        $display("FAIL single_pulse[edge %0d]: new_note=%b expected %b", i + 1, new_note, exp_nn);
      end
    end
    n_tests++;
    if (history !== {{(NS-1){16'h2020}}, 16'h4320} || current_note !== 16'h4320) begin
      n_fail++;
      $display("FAIL single_hist: hist=%h cur=%h expected slot0=4320 rest spaces", history, current_note);
    end
    tick(16'h4320, 1'b0, 1'b0);
    n_tests++;
    if (new_note !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: new_note=%b expected 0", new_note);
    end
  endtask

  task automatic test_rest_repeat();
    int pulses = 0;
    logic [15:0] seq [3];
    seq[0] = 16'h4320; seq[1] = SP; seq[2] = 16'h4320;
    tick(SP, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 6; i++) begin
        tick(seq[s], 1'b0, 1'b0);
        if (new_note === 1'b1) pulses++;
      end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL rest_repeat_pulses: got %0d expected 2", pulses);
    end
    n_tests++;
    if (history[31:0] !== 32'h43204320 || history[16*NS-1:32] !== ALL_SP[16*NS-1:32]) begin
      n_fail++;
      $display("FAIL rest_repeat_hist: hist=%h expected low two slots 4320", history);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    tick(SP, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(16'h4423, 1'b0, 1'b0);
      if (new_note === 1'b1) pulses++;
    end
    for (int i = 0; i < 6; i++) begin
      tick(16'h4520, 1'b0, 1'b0);
      if (new_note === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || history !== {{(NS-1){16'h2020}}, 16'h4520}) begin
      n_fail++;
      $display("FAIL glitch: pulses=%0d hist=%h expected 1 pulse, only 4520 in slot0", pulses, history);
    end
  endtask

  task automatic test_wrap_clear();
    logic [15:0] notes [10];
    notes[0] = 16'h4120; notes[1] = 16'h4220; notes[2] = 16'h4320; notes[3] = 16'h4420;
    notes[4] = 16'h4520; notes[5] = 16'h4620; notes[6] = 16'h4720; notes[7] = 16'h4123;
    notes[8] = 16'h4323; notes[9] = 16'h4623;
    tick(SP, 1'b0, 1'b1);
    for (int j = 0; j < 9; j++)
      for (int i = 0; i < 5; i++) tick(notes[j], 1'b0, 1'b0);
    n_tests++;
    if (history[16*7 +: 16] !== notes[1] || history[15:0] !== notes[8]) begin
      n_fail++;
      $display("FAIL wrap: slot7=%h slot0=%h expected %h %h", history[16*7 +: 16], history[15:0], notes[1], notes[8]);
    end
    for (int i = 0; i < 4; i++) tick(notes[9], 1'b0, 1'b0);
    tick(notes[9], 1'b1, 1'b0);
    n_tests++;
    if (history !== ALL_SP || new_note !== 1'b0 || current_note !== SP) begin
      n_fail++;
      $display("FAIL clear_vs_commit: hist=%h nn=%b cur=%h expected all spaces nn=0", history, new_note, current_note);
    end
  endtask

  task automatic test_reset_mid_qual();
    for (int i = 0; i < 5; i++) tick(16'h4320, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(16'h4720, 1'b0, 1'b0);
    tick(16'h4720, 1'b0, 1'b1);
    n_tests++;
    if (history !== ALL_SP || new_note !== 1'b0 || current_note !== SP) begin
      n_fail++;
      $display("FAIL reset_mid_qual: hist=%h nn=%b cur=%h expected reset values", history, new_note, current_note);
    end
    for (int i = 0; i < 5; i++) begin
      tick(16'h4720, 1'b0, 1'b0);
      n_tests++;
      if (new_note !== (i == 4)) begin
        n_fail++;
        $display("FAIL post_reset_pulse[edge %0d]: new_note=%b expected %b", i + 1, new_note, (i == 4));
      end
    end
    n_tests++;
    if (history !== {{(NS-1){16'h2020}}, 16'h4720} || current_note !== 16'h4720) begin
      n_fail++;
      $display("FAIL post_reset_hist: hist=%h cur=%h expected slot0=4720", history, current_note);
    end
  endtask

  task automatic test_random();
    logic [15:0] pool [8];
    logic [15:0] n;
    int run;
    pool[0] = SP;      pool[1] = 16'h4320; pool[2] = 16'h4423; pool[3] = 16'h4520;
    pool[4] = 16'h4620; pool[5] = 16'h4720; pool[6] = 16'h4120; pool[7] = 16'h4220;
    tick(SP, 1'b0, 1'b1);
    for (int r = 0; r < 150; r++) begin
      n   = pool[$urandom_range(0, 7)];
      run = $urandom_range(1, 7);
      for (int i = 0; i < run; i++) begin
        tick(n, ($urandom_range(0, 31) == 0), 1'b0);
        n_tests++;
        if (history !== model_hist() || new_note !== m_pulse || current_note !== m_last) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: hist=%h nn=%b cur=%h expected hist=%h nn=%b cur=%h",
                   r, i, history, new_note, current_note, model_hist(), m_pulse, m_last);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest_repeat();
    test_glitch();
    test_wrap_clear();
    test_reset_mid_qual();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_history_ticker.md
# note_history_ticker

Downstream consumer of the note-to-ASCII stage: takes the registered 16-bit two-character ASCII note name each cycle and qualifies it for stability. It pushes each newly played note into a shift history of the last `NUM_SLOTS` notes, drives a flat ASCII string to the alphanumeric display driver, and pulses `new_note` for scoring logic. Silence separates repeated notes, so C, rest, C records two entries.

## Interface
Parameters:
- `NUM_SLOTS`, 8: history depth in two-character slots; the string is `16*NUM_SLOTS` bits (8 slots fill a 16-char display).
- `HOLD_CYCLES`, 270000: number of consecutive equal samples after the first one required to commit a note (10 ms at 27 MHz); minimum 2.

Ports:
- `clk`, in, 1: system clock. One clock domain.
- `reset`, in, 1: synchronous, active-high.
- `ascii_note`, in, 16: `{letter, accidental}` in ASCII; `{8'h20, 8'h20}` means silence.
- `clear`, in, 1: synchronous history wipe.
- `history`, out, `16*NUM_SLOTS`: slot 0 (newest) is in bits [15:0]; slot k is in bits [16k+15:16k].
- `new_note`, out, 1: one-cycle pulse on the edge that pushes a note.
- `current_note`, out, 16: last committed value, which may be silence.

## Operation
- Registers: `cand` (16), `cnt` (counter sized to hold `HOLD_CYCLES-1`), `last` (16), `state`, the history shift register, and `new_note`.
- FSM states:
  - IDLE: the state after reset.
  - QUAL: qualifying a candidate.
  - HELD: `cand` has been committed; waiting for the input to change.
- Any state, `ascii_note != cand`: load `cand <= ascii_note`, set `cnt <= 0`, go to QUAL. A change always restarts qualification, including mid-QUAL.
- QUAL, `ascii_note == cand`, `cnt < HOLD_CYCLES-1`: increment `cnt`.
- QUAL, `ascii_note == cand`, `cnt == HOLD_CYCLES-1`: commit, then go to HELD.
- Commit rules:
  - If `cand == last`: no action.
  - Else if `cand` is silence: `last <= silence`; no push, no pulse.
  - Else: `last <= cand`; shift history up one slot (the oldest slot is discarded); slot 0 gets `cand`; `new_note <= 1`.
- IDLE or HELD with an unchanged input: hold all registers.
- Codes other than silence are passed through verbatim. No validation is done here.
- `clear`, below `reset` in priority:
  - Effect: every history slot becomes `16'h2020` and `last <= 16'h2020`.
  - `cand`, `cnt` and `state` are unaffected.
  - A commit on the same edge is suppressed (clear wins), and `new_note` stays 0.
- Reset values:
  - `history`: all `8'h20`.
  - `current_note`: `16'h2020`.
  - `new_note`: 0.
  - `cand`: `16'h2020`.
  - `cnt`: 0.
  - `state`: IDLE.
  - Consequence: silence present at reset never commits, and the first real note needs full qualification.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Commit latency: the value is first sampled at edge E0 and commits at edge E(HOLD_CYCLES). The input must be stable for HOLD_CYCLES+1 consecutive edges.
- `history`, `current_note` and `new_note` all update on the commit edge.
- `new_note` is high for exactly one cycle per push and low on every other edge.
- A glitch shorter than HOLD_CYCLES+1 edges never commits. It does restart qualification of the surrounding note, which then needs the full count again.
- `reset` asserted mid-QUAL: everything returns to reset values on that edge, and no partial commit happens.

## Structure
- Shared package (`note_pkg`):
  - `ASCII_SPACE = 8'h20`, `ASCII_POUND = 8'h23`, `NOTE_SILENCE = {ASCII_SPACE, ASCII_SPACE}`.
  - The state enum `{IDLE, QUAL, HELD}`.
  - The 4-bit note code constants shared with the note-to-ASCII stage.
- One sub-module, `note_stability_qualifier`:
  - Contents: `cand`, `cnt` and the FSM.
  - Outputs: `commit_valid` (one-cycle) and `commit_value`.
- The top level holds `last`, the history shift register, the clear logic and the output registers.

## Test plan
All scenarios use `HOLD_CYCLES=4` and `NUM_SLOTS=8`.
- Reset then silence for 20 cycles: `history` is all `16'h2020`, `new_note` stays 0, `current_note = 16'h2020`.
- Hold `"C "` (`16'h4320`) for 5 edges: `new_note` pulses on edge 5 only, `history[15:0] = 16'h4320`, and all other slots stay space.
- Sequence `"C "`, silence, `"C "`, each held 6 edges: two pulses, with `history[31:0] = {16'h4320, 16'h4320}`.
- `"D#"` held 3 edges, then `"E "` held 6 edges: only `"E "` (`16'h4520`) is pushed, and `"D#"` never appears.
- Push 9 distinct notes: slot 7 holds note 2 and note 1 is discarded. Then pulse `clear` on the edge where a tenth note would commit: history is all spaces and `new_note = 0`.
- Assert `reset` while in QUAL with `cnt = 2`: all outputs are at reset values on the next edge, and a later 5-edge hold commits normally.
